// File: rtl/rsc_viterbi_dec.sv
// Hard-decision register-exchange Viterbi decoder for the 4-state (7,5) RSC constituent code.
// Accepts one (sys, par) pair per valid cycle and emits the ML info bit TB_DEPTH symbols later.
module rsc_viterbi_dec #(
    parameter int unsigned TB_DEPTH = 16,
    parameter int unsigned METRIC_W = 5
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                in_valid_i,
    input  logic                sys_in_i,
    input  logic                par_in_i,
    output logic                out_valid_o,
    output logic                out_bit_o,
    output logic [METRIC_W-1:0] best_metric_o
);

    localparam int unsigned CntW = $clog2(TB_DEPTH + 1);
    localparam logic [METRIC_W-1:0] MaxM = '1;
    localparam logic [3:0][METRIC_W-1:0] PmInit = {MaxM, MaxM, MaxM, {METRIC_W{1'b0}}};

    function automatic logic [1:0] hamming(input logic s, input logic p,
                                           input logic xe, input logic pe);
        return {1'b0, s ^ xe} + {1'b0, p ^ pe};
    endfunction

    function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] m,
                                                    input logic [1:0] b);
        logic [METRIC_W:0] s;
        s = {1'b0, m} + (METRIC_W+1)'(b);
        return (s > {1'b0, MaxM}) ? MaxM : s[METRIC_W-1:0];
    endfunction

    logic [3:0][METRIC_W-1:0] pm_q, pm_d, pm_in, raw;
    logic [3:0][TB_DEPTH-1:0] path_q, path_d, path_in, path_acs;
    logic [CntW-1:0]          cnt_q, cnt_d, cnt_in, cnt_next;
    logic [METRIC_W-1:0]      best_q, best_d, acc_in, min_m, c0, c1;
    logic [METRIC_W:0]        acc_sum;
    logic                     out_valid_q, out_valid_d, out_bit_q, out_bit_d;
    logic [1:0]               idx, best_s, bm0, bm1;
    logic                     x0, p0;

    always_comb begin
        pm_in    = pm_q;
        path_in  = path_q;
        cnt_in   = cnt_q;
        acc_in   = best_q;
        raw      = '0;
        path_acs = '0;
        idx      = '0;
        x0       = 1'b0;
        p0       = 1'b0;
        bm0      = '0;
        bm1      = '0;
        c0       = '0;
        c1       = '0;
        // A start symbol is decoded from a freshly initialised trellis.
        if (start_i) begin
            pm_in   = PmInit;
            path_in = '0;
            cnt_in  = '0;
            acc_in  = '0;
        end
        // Next state {a,s1} is reached from {s1,0} (expects x0,p0) or {s1,1} (the complement).
        for (int i = 0; i < 4; i++) begin
            idx = 2'(i);
            x0  = idx[1] ^ idx[0];
            p0  = idx[1];
            bm0 = hamming(sys_in_i, par_in_i, x0, p0);
            bm1 = hamming(sys_in_i, par_in_i, ~x0, ~p0);
            c0  = sat_add(pm_in[{idx[0], 1'b0}], bm0);
            c1  = sat_add(pm_in[{idx[0], 1'b1}], bm1);
            if (c1 < c0) begin
                raw[i]      = c1;
                path_acs[i] = {path_in[{idx[0], 1'b1}][TB_DEPTH-2:0], ~x0};
            end else begin
                raw[i]      = c0;
                path_acs[i] = {path_in[{idx[0], 1'b0}][TB_DEPTH-2:0], x0};
            end
        end
        min_m  = raw[0];
        best_s = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (raw[i] < min_m) begin
                min_m  = raw[i];
                best_s = 2'(i);
            end
        end
        // best_metric tracks the un-normalised survivor metric: sum of the removed minima.
        acc_sum  = {1'b0, acc_in} + {1'b0, min_m};
        cnt_next = (cnt_in == CntW'(TB_DEPTH)) ? cnt_in : cnt_in + CntW'(1);

        pm_d        = pm_q;
        path_d      = path_q;
        cnt_d       = cnt_q;
        best_d      = best_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        if (in_valid_i) begin
            for (int i = 0; i < 4; i++) begin
                pm_d[i] = (raw[i] == MaxM) ? MaxM : raw[i] - min_m;
            end
            path_d      = path_acs;
            cnt_d       = cnt_next;
            best_d      = acc_sum[METRIC_W] ? MaxM : acc_sum[METRIC_W-1:0];
            out_valid_d = (cnt_next == CntW'(TB_DEPTH));
            out_bit_d   = path_acs[best_s][TB_DEPTH-1];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pm_q        <= PmInit;
            path_q      <= '0;
            cnt_q       <= '0;
            best_q      <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            pm_q        <= pm_d;
            path_q      <= path_d;
            cnt_q       <= cnt_d;
            best_q      <= best_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign out_bit_o     = out_bit_q;
    assign best_metric_o = best_q;

endmodule

// File: doc/rsc_viterbi_dec.md
# rsc_viterbi_dec

Hard-decision Viterbi decoder for one constituent stream of the team's rate-1/2 recursive systematic convolutional (RSC) encoder: 4 states, feedback polynomial 7 (1+D+D²), feed-forward polynomial 5 (1+D²). It accepts one (systematic, parity) bit pair per valid cycle and emits the maximum-likelihood information bit `TB_DEPTH` symbols later. Survivor paths are held in a register-exchange memory. The block sits on the receive side, after the channel/bit-slicer and before the deinterleaver/sink.

## Interface
- `TB_DEPTH`, 16, survivor path length in symbols and decode latency; 4..64.
- `METRIC_W`, 5, path-metric width in bits; ≥ 3.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  qualified by `in_valid`; the symbol is the first of a new block.
- `in_valid`  in  1  `sys_in`/`par_in` carry a symbol this cycle.
- `sys_in`  in  1  received systematic bit.
- `par_in`  in  1  received parity bit.
- `out_valid`  out  1  `out_bit` is a decoded bit; one-cycle pulse per emitted bit.
- `out_bit`  out  1  decoded information bit.
- `best_metric`  out  METRIC_W  smallest path metric after the last update.

## Operation
- State s = {s1,s2}, index 2·s1+s2. Encoder model: a = u^s1^s2; x = u; p = a^s2; next state = {a,s1}.
- Trellis: next state {a,s1} has two predecessors, {s1,0} and {s1,1}. For predecessor {s1,s2}:
  - expected pair: x = a^s1^s2, p = a^s2;
  - decision bit: u = x.
- Branch metric = Hamming distance between (`sys_in`,`par_in`) and the expected pair. Range 0..2.
- ACS, on each `in_valid`, for all 4 states in parallel:
  - candidate = pm[pred] + bm, saturating at 2^METRIC_W−1;
  - keep the smaller candidate; on a tie, keep the predecessor with s2=0;
  - new path = {selected pred path[TB_DEPTH-2:0], u}.
- Normalization: after ACS, subtract the minimum new metric from all four. Saturated values stay saturated.
- Initialization (reset, or `start`&`in_valid`):
  - pm = {0, max, max, max}, i.e. state 0 is known;
  - paths = 0;
  - symbol counter = 0.
  - With `start`, initialization applies before this symbol's ACS. The symbol itself is then processed normally as symbol 1.
- Symbol counter saturates at `TB_DEPTH`.
- Output rule: when the accepted symbol makes count ≥ `TB_DEPTH`:
  - find the best state, i.e. minimum new metric; ties go to the lowest index;
  - `out_bit` = path[TB_DEPTH-1] of that state;
  - `out_valid` = 1.
- Tail handling: the final `TB_DEPTH-1` bits of a block are emitted only when more symbols are supplied. Upstream appends `TB_DEPTH-1` filler symbols; the bits decoded from filler are discarded downstream.
- `in_valid`=0 leaves all state unchanged; `start` without `in_valid` is ignored.

## Timing
- Reset values: `out_valid`=0, `out_bit`=0, `best_metric`=0, pm as initialization, paths 0, count 0.
- Throughput: one symbol per cycle, no backpressure. Gaps in `in_valid` are allowed anywhere.
- Outputs are registered. `out_valid`/`out_bit`/`best_metric` update in the cycle after the accepting edge.
- Latency: the bit for symbol j (1-based since init) appears in the cycle after symbol j+TB_DEPTH−1 is accepted.
- `out_valid` deasserts in any cycle following a non-accepting edge.
- `reset` asserted mid-stream: all outputs drop immediately (asynchronously). No stale bits are emitted after release.
- `start` mid-stream: the next `out_valid` occurs only after `TB_DEPTH` new symbols. Undelivered bits of the old block are dropped.

## Test plan
- Reset, then 40 symbols (0,0), continuous `in_valid` → first `out_valid` is one cycle after symbol 16 is accepted. 25 bits are emitted, all 0, and `best_metric`=0 throughout.
- Info bits 1,0,0,0 then zeros, encoded to symbol pairs 11,01,01,00,01,01,00,… → first emitted bit is 1, followed by zeros; `best_metric`=0.
- Same stream with `par_in` flipped on symbol 3 → identical output bits; `best_metric`=1 from symbol 3 on.
- Random 200-bit block from a reference encoder, plus 15 filler symbols, with 2% spaced single errors and random `in_valid` gaps → all 200 bits match. Exactly 200 `out_valid` pulses precede the filler outputs.
- Pulse `reset` at symbol 10 of a stream → outputs are 0 immediately. After release, the first `out_valid` comes 16 symbols later.
- Assert `start` with symbol 30 of a running stream → no `out_valid` until 16 symbols after the start (inclusive). Decode is correct for the new block, which starts from state 0.
